// File: rtl/im_boot_loader.sv
// Instruction-memory port owner: passes CPU fetches through when idle, otherwise streams
// a little-endian byte image from the UART into consecutive words while stalling the CPU.
module im_boot_loader #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_abort,
  input  logic [7:0]        ld_byte,
  input  logic              ld_byte_vld,
  output logic              ld_byte_rdy,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd_en,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd_en,
  output logic              im_wr_en,
  output logic [15:0]       im_wdata
);

  typedef enum logic [2:0] {IDLE, LO, HI, WR, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] remaining;
  logic [15:0]       wdata;
  logic [ADDR_W:0]   req_end;
  logic              req_ok;
  logic              byte_hs;
  logic              err_set;

  // One extra bit so base+len cannot wrap before the range check.
  assign req_end = {1'b0, ld_base} + {1'b0, ld_len};
  assign req_ok  = (ld_len != '0) && (req_end <= DEPTH_W);
  assign byte_hs = ld_byte_vld && ld_byte_rdy;

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          if (req_ok) state_nxt = LO;
          else        err_set   = 1'b1;
        end
      end
      LO: begin
        if (ld_abort) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end else if (byte_hs) begin
          state_nxt = HI;
        end
      end
      HI: begin
        if (ld_abort) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end else if (byte_hs) begin
          state_nxt = WR;
        end
      end
      WR: begin
        if (ld_abort) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end else if (remaining == ADDR_W'(1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = LO;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ld_busy     = (state != IDLE);
  assign cpu_stall   = ld_busy;
  assign ld_byte_rdy = (state == LO) || (state == HI);
  assign im_addr     = ld_busy ? wr_ptr : cpu_addr;
  assign im_rd_en    = !ld_busy && cpu_rd_en;
  assign im_wr_en    = (state == WR);
  assign im_wdata    = wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      wdata     <= '0;
      ld_err    <= 1'b0;
      ld_done   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ld_err  <= err_set;
      ld_done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (ld_start && req_ok) begin
            wr_ptr    <= ld_base;
            remaining <= ld_len;
          end
        end
        LO: if (byte_hs && !ld_abort) wdata[7:0]  <= ld_byte;
        HI: if (byte_hs && !ld_abort) wdata[15:8] <= ld_byte;
        WR: begin
          wr_ptr    <= wr_ptr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Randomized bench for im_boot_loader with a falling-edge memory model and a word-level load reference.
module tb_im_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_start = 1'b0;
  logic [15:0] ld_base = '0;
  logic [15:0] ld_len = '0;
  logic        ld_abort = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_byte_vld = 1'b0;
  logic        ld_byte_rdy, ld_busy, ld_done, ld_err, cpu_stall;
  logic [15:0] cpu_addr = '0;
  logic        cpu_rd_en = 1'b0;
  logic [15:0] im_addr, im_wdata;
  logic        im_rd_en, im_wr_en;

  im_boot_loader #(.DEPTH(8192), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_abort(ld_abort), .ld_byte(ld_byte), .ld_byte_vld(ld_byte_vld), .ld_byte_rdy(ld_byte_rdy),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err), .cpu_addr(cpu_addr),
    .cpu_rd_en(cpu_rd_en), .cpu_stall(cpu_stall), .im_addr(im_addr), .im_rd_en(im_rd_en),
    .im_wr_en(im_wr_en), .im_wdata(im_wdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          done_cyc = 0;
  logic [15:0] mem [0:8191];
  logic [15:0] rdata;
  wr_t         wr_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model and protocol monitor, both on the memory's sampling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_wr_en) begin
        wr_log.push_back('{a: im_addr, d: im_wdata});
        mem[im_addr[12:0]] = im_wdata;
        chk("rdy_in_wr", {31'd0, ld_byte_rdy}, 32'd0);
      end
      if (im_rd_en) rdata = mem[im_addr[12:0]];
      if (ld_busy) begin
        chk("stall_busy", {31'd0, cpu_stall}, 32'd1);
        chk("rd_blocked", {31'd0, im_rd_en}, 32'd0);
      end
      if (ld_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ld_err) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken = 0;
    ld_byte_vld = 1'b0;
    repeat (gap) tick();
    ld_byte = b;
    ld_byte_vld = 1'b1;
    for (int k = 0; k < 20 && !taken; k++) begin
      if (ld_byte_rdy) taken = 1;
      tick();
    end
    if (!taken) chk("byte_timeout", 32'd0, 32'd1);
    ld_byte_vld = 1'b0;
  endtask

  task automatic start_load(input logic [15:0] base, input logic [15:0] len, output int acc);
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = len;
    tick();
    acc = cyc;
    ld_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 40 && done_cnt == d0; k++) tick();
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic cmp_writes(input string tag, input wr_t exp[$]);
    chk({tag, "_nwr"}, wr_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++) begin
      chk({tag, "_wa"}, {16'd0, wr_log[i].a}, {16'd0, exp[i].a});
      chk({tag, "_wd"}, {16'd0, wr_log[i].d}, {16'd0, exp[i].d});
    end
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic [15:0] exp);
    cpu_addr  = addr;
    cpu_rd_en = 1'b1;
    #1;
    chk("pass_addr", {16'd0, im_addr}, {16'd0, addr});
    chk("pass_rd", {31'd0, im_rd_en}, 32'd1);
    @(negedge clk);
    #1;
    chk("cpu_rdata", {16'd0, rdata}, {16'd0, exp});
    tick();
    cpu_rd_en = 1'b0;
  endtask

  // Full load: little-endian byte pairs land in consecutive words starting at base.
  task automatic run_load(input logic [15:0] base, input int len, input logic [7:0] bytes[$],
                          input int maxgap);
    wr_t exp[$];
    int  acc, d0, e0;
    bit  cont = 1;
    for (int i = 0; i < len; i++)
      exp.push_back('{a: base + 16'(i), d: {bytes[2*i+1], bytes[2*i]}});
    wr_log.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    start_load(base, 16'(len), acc);
    chk("busy_after_start", {29'd0, ld_busy, cpu_stall, ld_byte_rdy}, 32'd7);
    foreach (bytes[i]) begin
      int g = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
      if (g != 0) cont = 0;
      send_byte(bytes[i], g);
    end
    wait_done(d0);
    if (cont) chk("done_latency", done_cyc - acc + 1, 3 * len + 1);
    chk("no_err", err_cnt - e0, 0);
    tick();
    chk("stall_released", {31'd0, cpu_stall}, 32'd0);
    cmp_writes("load", exp);
    foreach (exp[i]) cpu_read(exp[i].a, exp[i].d);
  endtask

  task automatic reject(input logic [15:0] base, input logic [15:0] len);
    int acc, e0;
    e0 = err_cnt;
    start_load(base, len, acc);
    chk("rej_err", {31'd0, ld_err}, 32'd1);
    chk("rej_idle", {30'd0, ld_busy, cpu_stall}, 32'd0);
    tick();
    chk("rej_err_1cyc", {31'd0, ld_err}, 32'd0);
    chk("rej_cnt", err_cnt - e0, 1);
    chk("rej_still_idle", {31'd0, cpu_stall}, 32'd0);
  endtask

  initial begin
    logic [7:0] bq[$];
    wr_t        exp[$];
    int         acc, len;
    logic [15:0] base;

    for (int i = 0; i < 8192; i++) mem[i] = 16'hDEAD;
    #12;
    chk("rst_outs", {25'd0, ld_byte_rdy, ld_busy, ld_done, ld_err, cpu_stall, im_wr_en, 1'b0}, 32'd0);
    chk("rst_wdata", {16'd0, im_wdata}, 32'd0);
    rst_n = 1'b1;
    tick();

    bq = '{8'h34, 8'h12, 8'h78, 8'h56};
    run_load(16'h0010, 2, bq, 0);

    reject(16'h0000, 16'h0000);
    reject(16'h1FFF, 16'h0002);

    bq = '{8'hCD, 8'hAB};
    run_load(16'h1FFF, 1, bq, 0);

    for (int it = 0; it < 8; it++) begin
      len  = $urandom_range(5, 1);
      base = 16'($urandom_range(8192 - len, 0));
      bq.delete();
      for (int i = 0; i < 2 * len; i++) bq.push_back(8'($urandom));
      run_load(base, len, bq, (it < 3) ? 0 : ((it % 2 == 0) ? 5 : 3));
    end

    // Abort in HI after the first byte of the second word.
    base = 16'h0200;
    wr_log.delete();
    exp.delete();
    exp.push_back('{a: base, d: 16'hBEEF});
    start_load(base, 16'd3, acc);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'h11, 0);
    ld_abort = 1'b1;
    tick();
    ld_abort = 1'b0;
    chk("abort_err", {31'd0, ld_err}, 32'd1);
    chk("abort_idle", {30'd0, ld_busy, cpu_stall}, 32'd0);
    tick();
    chk("abort_err_1cyc", {31'd0, ld_err}, 32'd0);
    cmp_writes("abort", exp);
    cpu_read(base, 16'hBEEF);
    cpu_read(base + 16'd1, 16'hDEAD);

    // Async reset while the first word is in its write cycle.
    wr_log.delete();
    start_load(16'h0300, 16'd2, acc);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    chk("in_wr", {31'd0, im_wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {25'd0, ld_byte_rdy, ld_busy, ld_done, ld_err, cpu_stall, im_wr_en, 1'b0}, 32'd0);
    chk("arst_wdata", {16'd0, im_wdata}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_nwr", wr_log.size(), 0);
    bq = '{8'h55, 8'hAA, 8'h66, 8'h99};
    run_load(16'h0300, 2, bq, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
